rhd_spi_emu: RTL and testbench

RHD_SPI_EMU -- requirements
Module: rhd_spi_emu

---
 rtl/rhd_spi_if.sv | 28 ++
 rtl/rhd_spi_emu.sv | 243 ++++++++++++++++++++++++
 tb/tb_rhd_spi_emu.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/rhd_spi_if.sv
// SPI pins of the emulated headstage plus its frame status flags.
// The master modport drives the pins; the slave modport is the emulator side.
interface rhd_spi_if;
  logic CS;
  logic SCLK;
  logic MOSI;
  logic MISO;
  logic frame_done;
  logic frame_err;

  modport master (
    output CS,
    output SCLK,
    output MOSI,
    input  MISO,
    input  frame_done,
    input  frame_err
  );

  modport slave (
    input  CS,
    input  SCLK,
    input  MOSI,
    output MISO,
    output frame_done,
    output frame_err
  );
endinterface

// File: rtl/rhd_spi_emu.sv
// Behavioural SPI-slave emulator: 16-bit command frames, 2-frame response pipeline,
// per-channel ramp counters on streams A/B and a small register file with ID bytes.
module rhd_spi_emu #(
  parameter int unsigned STARTING_SEED = 0,
  parameter int unsigned NUM_CH        = 32,
  parameter bit          DDR           = 1'b1,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rstn,
  rhd_spi_if.slave   spi
);

  localparam int unsigned CNT_W   = 5;
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned REG_WR  = 18;
  localparam int unsigned RIDX_W  = 5;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WORD_W);

  typedef enum logic {S_IDLE, S_FRAME} state_t;

  // Input synchronisers; CS resets high so reset never fabricates an idle-to-active edge
  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic                   cs_d, sclk_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.CS};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
      cs_d      <= cs_sync[SYNC_STAGES-1];
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  logic cs_s, sclk_s, mosi_s;
  logic cs_fall_c, cs_rise_c, sclk_rise_c, sclk_fall_c;

  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign cs_fall_c   = cs_d & ~cs_s;
  assign cs_rise_c   = ~cs_d & cs_s;
  assign sclk_rise_c = ~sclk_d & sclk_s;
  assign sclk_fall_c = sclk_d & ~sclk_s;

  // Frame FSM and registered pin outputs
  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [WORD_W-1:0]   shreg, shreg_n;
  logic                miso, miso_n;
  logic                done, done_n;
  logic                err, err_n;
  logic                commit_c;
  logic [3:0]          bit_idx_c;

  logic [WORD_W-1:0]   cur_a, cur_b, nxt_a, nxt_b;

  assign bit_idx_c = 4'(5'd15 - cnt);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
      shreg <= '0;
      miso  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      shreg <= shreg_n;
      miso  <= miso_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shreg_n  = shreg;
    miso_n   = miso;
    done_n   = 1'b0;
    err_n    = err;
    commit_c = 1'b0;
    case (state)
      S_IDLE: begin
        miso_n = 1'b0;
        if (cs_fall_c) begin
          state_n = S_FRAME;
          cnt_n   = '0;
          shreg_n = '0;
          miso_n  = cur_a[WORD_W-1];
        end
      end
      S_FRAME: begin
        if (cs_rise_c) begin
          state_n = S_IDLE;
          miso_n  = 1'b0;
          if (cnt == FULL) begin
            done_n   = 1'b1;
            commit_c = 1'b1;
          end else if (cnt != '0) begin
            err_n = 1'b1;
          end
        end else if (sclk_rise_c && (cnt != FULL)) begin
          cnt_n   = cnt + CNT_W'(1);
          shreg_n = {shreg[WORD_W-2:0], mosi_s};
          if (DDR) miso_n = cur_b[bit_idx_c];
        end else if (sclk_fall_c && (cnt != '0) && (cnt != FULL)) begin
          miso_n = cur_a[bit_idx_c];
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign spi.MISO       = miso;
  assign spi.frame_done = done;
  assign spi.frame_err  = err;

  // Command field decode of the captured word
  logic [1:0]        op_c;
  logic [ADDR_W-1:0] addr_c;
  logic [BYTE_W-1:0] lo_c;
  logic              is_conv_c, is_clr_c, is_wr_c, is_rd_c, conv_hit_c, reg_wr_ok_c;

  assign op_c        = shreg[15:14];
  assign addr_c      = shreg[13:8];
  assign lo_c        = shreg[7:0];
  assign is_conv_c   = (op_c == 2'b00) && (lo_c[7:1] == 7'd0);
  assign is_clr_c    = (shreg == 16'h6A00);
  assign is_wr_c     = (op_c == 2'b10);
  assign is_rd_c     = (op_c == 2'b11) && (lo_c == 8'h00);
  assign conv_hit_c  = is_conv_c && (32'(addr_c) < NUM_CH);
  assign reg_wr_ok_c = (32'(addr_c) < REG_WR);

  function automatic logic [WORD_W-1:0] init_a(input int unsigned ch);
    return WORD_W'(ch + STARTING_SEED);
  endfunction

  function automatic logic [WORD_W-1:0] init_b(input int unsigned ch);
    return WORD_W'(ch + NUM_CH + STARTING_SEED);
  endfunction

  logic [WORD_W-1:0] ctr_a [NUM_CH];
  logic [WORD_W-1:0] ctr_b [NUM_CH];
  logic [BYTE_W-1:0] regs  [REG_WR];

  logic [WORD_W-1:0] ctr_a_rd_c, ctr_b_rd_c;
  logic [BYTE_W-1:0] reg_rd_c;
  logic [WORD_W-1:0] resp_a_c, resp_b_c;

  always_comb begin
    ctr_a_rd_c = '0;
    ctr_b_rd_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ADDR_W'(i) == addr_c) begin
        ctr_a_rd_c = ctr_a[i];
        ctr_b_rd_c = ctr_b[i];
      end
    end
  end

  // Writable bytes first, then the fixed "INTAN" ID and revision byte
  always_comb begin
    reg_rd_c = '0;
    if (reg_wr_ok_c) begin
      reg_rd_c = regs[RIDX_W'(addr_c)];
    end else begin
      case (addr_c)
        6'd40:   reg_rd_c = 8'h49;
        6'd41:   reg_rd_c = 8'h4E;
        6'd42:   reg_rd_c = 8'h54;
        6'd43:   reg_rd_c = 8'h41;
        6'd44:   reg_rd_c = 8'h4E;
        6'd63:   reg_rd_c = 8'h01;
        default: reg_rd_c = 8'h00;
      endcase
    end
  end

  always_comb begin
    resp_a_c = '0;
    resp_b_c = '0;
    if (conv_hit_c) begin
      resp_a_c = ctr_a_rd_c;
      resp_b_c = ctr_b_rd_c;
    end else if (is_wr_c) begin
      resp_a_c = {8'hFF, lo_c};
      resp_b_c = {8'hFF, lo_c};
    end else if (is_rd_c) begin
      resp_a_c = {8'h00, reg_rd_c};
      resp_b_c = {8'h00, reg_rd_c};
    end
  end

  // Response pipeline and channel counters advance only on a completed frame
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_a <= '0;
      cur_b <= '0;
      nxt_a <= '0;
      nxt_b <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        ctr_a[i] <= init_a(i);
        ctr_b[i] <= init_b(i);
      end
    end else if (commit_c) begin
      cur_a <= nxt_a;
      cur_b <= nxt_b;
      nxt_a <= resp_a_c;
      nxt_b <= resp_b_c;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (is_clr_c || (conv_hit_c && lo_c[0] && (ADDR_W'(i) == addr_c))) begin
          ctr_a[i] <= init_a(i);
          ctr_b[i] <= init_b(i);
        end else if (conv_hit_c && (ADDR_W'(i) == addr_c)) begin
          ctr_a[i] <= ctr_a[i] + WORD_W'(1);
          ctr_b[i] <= ctr_b[i] + WORD_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < REG_WR; i++) regs[i] <= '0;
    end else if (commit_c && is_wr_c && reg_wr_ok_c) begin
      regs[RIDX_W'(addr_c)] <= lo_c;
    end
  end

endmodule

// File: tb/tb_rhd_spi_emu.sv
// Directed bench for rhd_spi_emu: a frame table with hand-derived pipelined responses,
// plus sequences for zero-edge/aborted frames and a mid-frame reset.
module tb_rhd_spi_emu;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  rhd_spi_if spi();

  rhd_spi_emu #(
    .STARTING_SEED(0),
    .NUM_CH       (32),
    .DDR          (1'b1),
    .SYNC_STAGES  (2)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .spi (spi)
  );

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  always @(negedge clk) if (spi.frame_done === 1'b1) done_cnt++;

  typedef struct {
    logic [15:0] cmd;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;

  vec_t tbl [30];

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%04h required=0x%04h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One CS-framed transfer with 'edges' SCLK pulses, half period 8 clk; A sampled
  // before each rise, B before each fall.
  task automatic frame(input logic [15:0] cmd, input int edges,
                       output logic [15:0] a, output logic [15:0] b, output int ndone);
    int d0;
    a  = '0;
    b  = '0;
    d0 = done_cnt;
    spi.MOSI = cmd[15];
    spi.CS   = 1'b0;
    wait_clk(8);
    a[15] = spi.MISO;
    for (int k = 1; k <= edges; k++) begin
      spi.SCLK = 1'b1;
      wait_clk(8);
      b[16-k] = spi.MISO;
      spi.SCLK = 1'b0;
      spi.MOSI = (k < 16) ? cmd[15-k] : 1'b0;
      wait_clk(8);
      if (k < 16) a[15-k] = spi.MISO;
    end
    spi.CS = 1'b1;
    wait_clk(12);
    ndone = done_cnt - d0;
  endtask

  task automatic full_frame(input string name, input logic [15:0] cmd,
                            input logic [15:0] ea, input logic [15:0] eb);
    logic [15:0] a, b;
    int nd;
    frame(cmd, 16, a, b, nd);
    check16({name, "_a"}, a, ea);
    check16({name, "_b"}, b, eb);
    check16({name, "_done"}, 16'(nd), 16'd1);
    check16({name, "_idle_miso"}, 16'(spi.MISO), 16'd0);
  endtask

  initial begin
    logic [15:0] a, b;
    int nd;

    tbl[0]  = '{16'h0000, 16'h0000, 16'h0000};
    tbl[1]  = '{16'h0100, 16'h0000, 16'h0000};
    tbl[2]  = '{16'h0000, 16'h0000, 16'h0020};
    tbl[3]  = '{16'h0000, 16'h0001, 16'h0021};
    tbl[4]  = '{16'h85A5, 16'h0001, 16'h0021};
    tbl[5]  = '{16'hC500, 16'h0002, 16'h0022};
    tbl[6]  = '{16'h9411, 16'hFFA5, 16'hFFA5};
    tbl[7]  = '{16'hD400, 16'h00A5, 16'h00A5};
    tbl[8]  = '{16'hE800, 16'hFF11, 16'hFF11};
    tbl[9]  = '{16'hE900, 16'h0000, 16'h0000};
    tbl[10] = '{16'hEA00, 16'h0049, 16'h0049};
    tbl[11] = '{16'hEB00, 16'h004E, 16'h004E};
    tbl[12] = '{16'hEC00, 16'h0054, 16'h0054};
    tbl[13] = '{16'hFF00, 16'h0041, 16'h0041};
    tbl[14] = '{16'h0300, 16'h004E, 16'h004E};
    tbl[15] = '{16'h0300, 16'h0001, 16'h0001};
    tbl[16] = '{16'h0300, 16'h0003, 16'h0023};
    tbl[17] = '{16'h0301, 16'h0004, 16'h0024};
    tbl[18] = '{16'h0300, 16'h0005, 16'h0025};
    tbl[19] = '{16'h0300, 16'h0006, 16'h0026};
    tbl[20] = '{16'h6A00, 16'h0003, 16'h0023};
    tbl[21] = '{16'h0300, 16'h0004, 16'h0024};
    tbl[22] = '{16'h5500, 16'h0000, 16'h0000};
    tbl[23] = '{16'h2800, 16'h0003, 16'h0023};
    tbl[24] = '{16'h0080, 16'h0000, 16'h0000};
    tbl[25] = '{16'hC501, 16'h0000, 16'h0000};
    tbl[26] = '{16'h3F00, 16'h0000, 16'h0000};
    tbl[27] = '{16'h0000, 16'h0000, 16'h0000};
    tbl[28] = '{16'h0000, 16'h0000, 16'h0000};
    tbl[29] = '{16'h0000, 16'h0000, 16'h0020};

    spi.CS   = 1'b1;
    spi.SCLK = 1'b0;
    spi.MOSI = 1'b0;
    rstn     = 1'b0;
    wait_clk(3);
    check16("rst_miso", 16'(spi.MISO), 16'd0);
    check16("rst_done", 16'(spi.frame_done), 16'd0);
    check16("rst_err",  16'(spi.frame_err), 16'd0);
    rstn = 1'b1;
    wait_clk(5);

    for (int i = 0; i < 30; i++)
      full_frame($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].ea, tbl[i].eb);
    check16("table_err", 16'(spi.frame_err), 16'd0);

    // Zero-edge frame: neither a frame nor an error
    frame(16'h0000, 0, a, b, nd);
    check16("zero_edge_done", 16'(nd), 16'd0);
    check16("zero_edge_err", 16'(spi.frame_err), 16'd0);

    // Aborted WRITE(6,0x77) after 7 edges: error, no done, pipeline untouched
    frame(16'h8677, 7, a, b, nd);
    check16("abort_done", 16'(nd), 16'd0);
    check16("abort_err", 16'(spi.frame_err), 16'd1);
    full_frame("post_abort0", 16'hC600, 16'h0001, 16'h0021);
    full_frame("post_abort1", 16'h0000, 16'h0002, 16'h0022);
    full_frame("post_abort2", 16'h0000, 16'h0000, 16'h0000);
    check16("abort_err_sticky", 16'(spi.frame_err), 16'd1);

    // Reset pulsed in the middle of a frame
    spi.MOSI = 1'b1;
    spi.CS   = 1'b0;
    wait_clk(8);
    for (int k = 0; k < 3; k++) begin
      spi.SCLK = 1'b1;
      wait_clk(8);
      spi.SCLK = 1'b0;
      wait_clk(8);
    end
    rstn = 1'b0;
    wait_clk(2);
    check16("midrst_miso", 16'(spi.MISO), 16'd0);
    check16("midrst_err", 16'(spi.frame_err), 16'd0);
    rstn = 1'b1;
    wait_clk(6);
    spi.CS = 1'b1;
    wait_clk(10);
    check16("midrst_err_after", 16'(spi.frame_err), 16'd0);
    full_frame("midrst_f0", 16'h0000, 16'h0000, 16'h0000);
    full_frame("midrst_f1", 16'h0000, 16'h0000, 16'h0000);
    full_frame("midrst_f2", 16'h0000, 16'h0000, 16'h0020);
    check16("midrst_err_end", 16'(spi.frame_err), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
